// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO types, reset constants and parameter checks
//
// Purpose: common definitions for the single-clock and dual-clock FIFO
// pointer/status generators.
//   thresh_ok()    : legal almost-empty / almost-full threshold window
//   count_width()  : width of an occupancy counter able to hold 0..DEPTH
//   fifo_status_t  : registered status flag bundle
package fifo_pkg;

   typedef int unsigned width_t;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

   localparam fifo_status_t STATUS_RST = '{
      full:         1'b0,
      empty:        1'b1,
      almost_full:  1'b0,
      almost_empty: 1'b1,
      overflow:     1'b0,
      underflow:    1'b0
   };

   // Thresholds must leave at least one level between the two almost flags
   // and stay strictly inside the empty..full range.
   function automatic bit thresh_ok(input int ae, input int af, input int depth);
      return (ae >= 1) && (ae < af) && (af <= depth - 1);
   endfunction

   // One extra bit so that DEPTH itself is representable.
   function automatic width_t count_width(input width_t addrsize);
      return addrsize + 1;
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - binary address pointer with increment enable and natural wrap
//
// Ports:
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset, pointer returns to 0
//   inc_i      : advance pointer by one this cycle
//   ptr_o      : current pointer (registered)
//   ptr_nxt_o  : pointer value after this edge (combinational)
module fifo_ptr #(
   parameter int ADDRSIZE = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                inc_i,
   output logic [ADDRSIZE-1:0] ptr_o,
   output logic [ADDRSIZE-1:0] ptr_nxt_o
);

   logic [ADDRSIZE-1:0] ptr_q;
   logic [ADDRSIZE-1:0] ptr_d;

   // Power-of-two depth: plain binary overflow gives the DEPTH-1 -> 0 wrap.
   always_comb begin
      ptr_d = ptr_q + ADDRSIZE'(inc_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o     = ptr_q;
   assign ptr_nxt_o = ptr_d;

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO pointers, occupancy and status flags
//
// Ports:
//   wclk          : sole clock, rising edge
//   wrst_n        : asynchronous active-low reset
//   winc / rinc   : write / read requests
//   clr_err       : synchronous clear of sticky overflow/underflow
//   waddr / raddr : RAM write / read addresses (current pointers)
//   wen / ren     : accepted write / read this cycle (combinational)
//   full, empty, almost_full, almost_empty : registered flags
//   count         : registered occupancy 0..DEPTH
//   overflow, underflow : sticky error flags
module sync_fifo_flags
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE  = 4,
   parameter int AF_THRESH = (1 << ADDRSIZE) - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                wclk,
   input  logic                wrst_n,
   input  logic                winc,
   input  logic                rinc,
   input  logic                clr_err,
   output logic [ADDRSIZE-1:0] waddr,
   output logic [ADDRSIZE-1:0] raddr,
   output logic                wen,
   output logic                ren,
   output logic                full,
   output logic                empty,
   output logic                almost_full,
   output logic                almost_empty,
   output logic [ADDRSIZE:0]   count,
   output logic                overflow,
   output logic                underflow
);

   localparam int DEPTH = 1 << ADDRSIZE;
   localparam int CW    = int'(count_width(width_t'(ADDRSIZE)));

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   if (!thresh_ok(AE_THRESH, AF_THRESH, DEPTH)) begin : g_bad_thresh
      $error("sync_fifo_flags: need 1 <= AE_THRESH < AF_THRESH <= DEPTH-1");
   end

   logic [ADDRSIZE-1:0] wptr_nxt;
   logic [ADDRSIZE-1:0] rptr_nxt;

   logic                dir_q;
   logic                dir_d;
   logic [CW-1:0]       count_q;
   logic [CW-1:0]       count_d;
   fifo_status_t        status_q;
   fifo_status_t        status_d;
   logic                ptr_eq;

   // Flags come from registers only, so requests never reach a flag
   // through a combinational path.
   assign wen = winc & ~status_q.full;
   assign ren = rinc & ~status_q.empty;

   fifo_ptr #(.ADDRSIZE(ADDRSIZE)) u_wptr (
      .clk_i     (wclk),
      .rst_ni    (wrst_n),
      .inc_i     (wen),
      .ptr_o     (waddr),
      .ptr_nxt_o (wptr_nxt)
   );

   fifo_ptr #(.ADDRSIZE(ADDRSIZE)) u_rptr (
      .clk_i     (wclk),
      .rst_ni    (wrst_n),
      .inc_i     (ren),
      .ptr_o     (raddr),
      .ptr_nxt_o (rptr_nxt)
   );

   always_comb begin
      // Direction records whether the last unbalanced operation was a write;
      // it disambiguates equal pointers as full (1) or empty (0).
      dir_d = dir_q;
      if (wen & ~ren) begin
         dir_d = 1'b1;
      end else if (ren & ~wen) begin
         dir_d = 1'b0;
      end

      count_d = count_q + CW'(wen) - CW'(ren);
      ptr_eq  = (wptr_nxt == rptr_nxt);

      status_d              = status_q;
      status_d.full         = ptr_eq & dir_d;
      status_d.empty        = ptr_eq & ~dir_d;
      status_d.almost_full  = (count_d >= AF_C);
      status_d.almost_empty = (count_d <= AE_C);
      // A fresh error event in the clearing cycle must not be lost.
      status_d.overflow     = (winc & status_q.full)  | (status_q.overflow  & ~clr_err);
      status_d.underflow    = (rinc & status_q.empty) | (status_q.underflow & ~clr_err);
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         dir_q    <= 1'b0;
         count_q  <= '0;
         status_q <= STATUS_RST;
      end else begin
         dir_q    <= dir_d;
         count_q  <= count_d;
         status_q <= status_d;
      end
   end

   assign count        = count_q;
   assign full         = status_q.full;
   assign empty        = status_q.empty;
   assign almost_full  = status_q.almost_full;
   assign almost_empty = status_q.almost_empty;
   assign overflow     = status_q.overflow;
   assign underflow    = status_q.underflow;

   a_full_cnt : assert property (@(posedge wclk) disable iff (!wrst_n)
      status_q.full == (count_q == DEPTH_C));
   a_empty_cnt : assert property (@(posedge wclk) disable iff (!wrst_n)
      status_q.empty == (count_q == '0));
   a_cnt_range : assert property (@(posedge wclk) disable iff (!wrst_n)
      count_q <= DEPTH_C);

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - directed and random-walk bench for sync_fifo_flags
module tb_sync_fifo_flags;

   logic       wclk = 1'b0;
   logic       wrst_n;
   logic       winc;
   logic       rinc;
   logic       clr_err;
   logic [3:0] waddr;
   logic [3:0] raddr;
   logic       wen;
   logic       ren;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int n_vec = 0;
   int n_err = 0;

   sync_fifo_flags dut (
      .wclk         (wclk),
      .wrst_n       (wrst_n),
      .winc         (winc),
      .rinc         (rinc),
      .clr_err      (clr_err),
      .waddr        (waddr),
      .raddr        (raddr),
      .wen          (wen),
      .ren          (ren),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 wclk = ~wclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge wclk);
      #1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_count"}, 32'(count), 0);
      chk({tag, "_empty"}, 32'(empty), 1);
      chk({tag, "_ae"},    32'(almost_empty), 1);
      chk({tag, "_full"},  32'(full), 0);
      chk({tag, "_af"},    32'(almost_full), 0);
      chk({tag, "_ovf"},   32'(overflow), 0);
      chk({tag, "_unf"},   32'(underflow), 0);
      chk({tag, "_waddr"}, 32'(waddr), 0);
      chk({tag, "_raddr"}, 32'(raddr), 0);
   endtask

   int        mcnt;
   int        mwp;
   int        mrp;
   bit        movf;
   bit        munf;
   bit        mw;
   bit        mr;
   int        exp_ra;
   int        q[$];

   initial begin
      wrst_n  = 1'b0;
      winc    = 1'b0;
      rinc    = 1'b0;
      clr_err = 1'b0;
      step();
      step();
      chk_reset_state("rst");
      wrst_n = 1'b1;

      // Five writes, then asynchronous reset between edges.
      winc = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk("pre_fill_count", 32'(count), 32'(i));
      end
      winc = 1'b0;
      chk("pre_fill_waddr", 32'(waddr), 5);
      #3;
      wrst_n = 1'b0;
      #1;
      chk_reset_state("midrst");
      step();
      wrst_n = 1'b1;

      // Fill from empty: almost_full at 14, full at 16, waddr wraps.
      winc = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         step();
         chk("fill_count", 32'(count), 32'(i));
         chk("fill_empty", 32'(empty), 0);
         chk("fill_af",    32'(almost_full), (i >= 14) ? 1 : 0);
         chk("fill_ae",    32'(almost_empty), (i <= 2) ? 1 : 0);
         chk("fill_full",  32'(full), (i == 16) ? 1 : 0);
      end
      winc = 1'b0;
      chk("fill_waddr", 32'(waddr), 0);
      chk("fill_raddr", 32'(raddr), 0);

      // Overflow on write-only at full.
      winc = 1'b1;
      #1;
      chk("ovf_wen", 32'(wen), 0);
      step();
      winc = 1'b0;
      chk("ovf_flag",  32'(overflow), 1);
      chk("ovf_count", 32'(count), 16);
      chk("ovf_full",  32'(full), 1);
      chk("ovf_waddr", 32'(waddr), 0);
      chk("ovf_raddr", 32'(raddr), 0);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("ovf_clr", 32'(overflow), 0);

      // Full with simultaneous read and write.
      winc = 1'b1;
      rinc = 1'b1;
      #1;
      chk("frw_wen", 32'(wen), 0);
      chk("frw_ren", 32'(ren), 1);
      step();
      winc = 1'b0;
      rinc = 1'b0;
      chk("frw_count", 32'(count), 15);
      chk("frw_full",  32'(full), 0);
      chk("frw_ovf",   32'(overflow), 1);
      chk("frw_raddr", 32'(raddr), 1);
      chk("frw_af",    32'(almost_full), 1);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;

      // Drain to empty.
      rinc = 1'b1;
      for (int i = 14; i >= 0; i--) begin
         step();
         chk("drain_count", 32'(count), 32'(i));
      end
      rinc = 1'b0;
      chk("drain_empty", 32'(empty), 1);
      chk("drain_ae",    32'(almost_empty), 1);
      chk("drain_raddr", 32'(raddr), 0);

      // Underflow, then set-wins-over-clear, then clear.
      rinc = 1'b1;
      #1;
      chk("unf_ren", 32'(ren), 0);
      step();
      chk("unf_flag", 32'(underflow), 1);
      clr_err = 1'b1;
      step();
      chk("unf_setwins", 32'(underflow), 1);
      rinc = 1'b0;
      step();
      clr_err = 1'b0;
      chk("unf_clr", 32'(underflow), 0);

      // Empty with simultaneous read and write: no fall-through.
      winc = 1'b1;
      rinc = 1'b1;
      #1;
      chk("erw_wen", 32'(wen), 1);
      chk("erw_ren", 32'(ren), 0);
      step();
      winc = 1'b0;
      rinc = 1'b0;
      chk("erw_count", 32'(count), 1);
      chk("erw_empty", 32'(empty), 0);
      chk("erw_unf",   32'(underflow), 1);
      chk("erw_waddr", 32'(waddr), 1);
      chk("erw_raddr", 32'(raddr), 0);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;

      // Random walk against a scoreboard queue of written addresses.
      mcnt = 1;
      mwp  = 1;
      mrp  = 0;
      movf = 1'b0;
      munf = 1'b0;
      q.push_back(0);
      for (int i = 0; i < 1000; i++) begin
         winc = 1'($urandom_range(0, 1));
         rinc = 1'($urandom_range(0, 1));
         #1;
         mw = winc && (mcnt < 16);
         mr = rinc && (mcnt > 0);
         chk("rw_wen",   32'(wen), 32'(mw));
         chk("rw_ren",   32'(ren), 32'(mr));
         chk("rw_waddr", 32'(waddr), 32'(mwp));
         if (mr) begin
            exp_ra = q.pop_front();
            chk("rw_raddr", 32'(raddr), 32'(exp_ra));
         end
         if (mw) begin
            q.push_back(mwp);
         end
         movf = movf || (winc && (mcnt == 16));
         munf = munf || (rinc && (mcnt == 0));
         mcnt = mcnt + int'(mw) - int'(mr);
         if (mw) mwp = (mwp + 1) % 16;
         if (mr) mrp = (mrp + 1) % 16;
         step();
         chk("rw_count", 32'(count), 32'(mcnt));
         chk("rw_full",  32'(full), (mcnt == 16) ? 1 : 0);
         chk("rw_empty", 32'(empty), (mcnt == 0) ? 1 : 0);
         chk("rw_af",    32'(almost_full), (mcnt >= 14) ? 1 : 0);
         chk("rw_ae",    32'(almost_empty), (mcnt <= 2) ? 1 : 0);
         chk("rw_ovf",   32'(overflow), 32'(movf));
         chk("rw_unf",   32'(underflow), 32'(munf));
         chk("rw_ptrdiff", 32'(4'(waddr - raddr)), 32'(mcnt % 16));
      end
      winc = 1'b0;
      rinc = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
